scytale_decryption: RTL and testbench

Decryption engine for the Scytale cipher, sitting directly downstream of the decryption register file. It consumes that block's `scytale_key` output, split as key_N = columns and key_M = rows. It receives ciphertext from the demux one character per cycle and buffers it until the start token arrives. It then emits the plaintext one character per cycle toward the output mux.

---
 rtl/scytale_decryption.sv | 138 +++++++++++++
 tb/tb_scytale_decryption.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/scytale_decryption.sv
// Scytale cipher decryption engine.
// Buffers ciphertext characters until the start token arrives, validates the
// latched key against the message length, then emits the plaintext one
// character per cycle by striding through the buffer in steps of key_M.
module scytale_decryption #(
    parameter int                   D_WIDTH                = 8,
    parameter int                   KEY_WIDTH              = 8,
    parameter int                   MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0]   START_DECRYPTION_TOKEN = 8'hFA
) (
    input  logic                    clk,
    input  logic                    rst_n,     // active-high asynchronous reset
    input  logic [D_WIDTH-1:0]      data_i,
    input  logic                    valid_i,
    input  logic [KEY_WIDTH-1:0]    key_N,
    input  logic [KEY_WIDTH-1:0]    key_M,
    output logic [D_WIDTH-1:0]      data_o,
    output logic                    valid_o,
    output logic                    busy,
    output logic                    error
);

    localparam int CW = $clog2(MAX_NOF_CHARS + 1);  // count width (0..MAX)
    localparam int AW = $clog2(MAX_NOF_CHARS);      // buffer address width
    localparam int LW = 2 * KEY_WIDTH;              // full product width

    typedef enum logic {
        COLLECT = 1'b0,
        DECRYPT = 1'b1
    } state_t;

    state_t               r_state;
    logic [D_WIDTH-1:0]   r_buf [MAX_NOF_CHARS];
    logic [CW-1:0]        r_count;
    logic                 r_ovf;
    logic [LW-1:0]        r_len;
    logic [KEY_WIDTH-1:0] r_key_m;
    logic [LW-1:0]        r_ptr;
    logic [LW-1:0]        r_out_cnt;
    logic [D_WIDTH-1:0]   r_data_o;
    logic                 r_valid_o;
    logic                 r_busy;
    logic                 r_error;

    logic                 w_is_token;
    logic                 w_has_room;
    logic                 w_store;
    logic [LW-1:0]        w_len;
    logic                 w_reject;
    logic [LW-1:0]        w_ptr_step;
    logic [LW-1:0]        w_ptr_next;

    assign w_is_token = (data_i == START_DECRYPTION_TOKEN);
    assign w_has_room = (r_count < CW'(MAX_NOF_CHARS));
    assign w_store    = (r_state == COLLECT) && valid_i && !w_is_token && w_has_room;

    // Message length from the live key; only used in the token cycle.
    assign w_len      = LW'(key_N) * LW'(key_M);
    assign w_reject   = r_ovf || (key_N == '0) || (key_M == '0) || (w_len != LW'(r_count));

    // Column stride; stepping past the end wraps to the start of the next column.
    assign w_ptr_step = r_ptr + LW'(r_key_m);
    assign w_ptr_next = (w_ptr_step >= r_len) ? (w_ptr_step - r_len + LW'(1)) : w_ptr_step;

    // Character buffer: no reset, only the count is cleared between messages.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_buf[r_count[AW-1:0]] <= data_i;
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state   <= COLLECT;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_len     <= '0;
            r_key_m   <= '0;
            r_ptr     <= '0;
            r_out_cnt <= '0;
            r_data_o  <= '0;
            r_valid_o <= 1'b0;
            r_busy    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_error   <= 1'b0;
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
            case (r_state)
                COLLECT: begin
                    if (valid_i) begin
                        if (!w_is_token) begin
                            if (w_has_room) r_count <= r_count + CW'(1);
                            else            r_ovf   <= 1'b1;
                        end else if (r_count != '0) begin
                            if (w_reject) begin
                                r_error <= 1'b1;
                                r_count <= '0;
                                r_ovf   <= 1'b0;
                            end else begin
                                // Setup cycle: keys latched, output starts next cycle.
                                r_state   <= DECRYPT;
                                r_busy    <= 1'b1;
                                r_len     <= w_len;
                                r_key_m   <= key_M;
                                r_ptr     <= '0;
                                r_out_cnt <= '0;
                            end
                        end
                    end
                end
                DECRYPT: begin
                    if (r_out_cnt < r_len) begin
                        r_data_o  <= r_buf[r_ptr[AW-1:0]];
                        r_valid_o <= 1'b1;
                        r_out_cnt <= r_out_cnt + LW'(1);
                        r_ptr     <= w_ptr_next;
                    end else begin
                        r_state   <= COLLECT;
                        r_busy    <= 1'b0;
                        r_count   <= '0;
                        r_out_cnt <= '0;
                        r_ptr     <= '0;
                        r_ovf     <= 1'b0;
                    end
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

    assign data_o  = r_data_o;
    assign valid_o = r_valid_o;
    assign busy    = r_busy;
    assign error   = r_error;

endmodule

// File: tb/tb_scytale_decryption.sv
// Directed testbench for scytale_decryption.
module tb_scytale_decryption;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_i;
    logic       valid_i;
    logic [7:0] key_N;
    logic [7:0] key_M;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy;
    logic       error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ct_q [$];
    logic [7:0] pt_q [$];
    logic [7:0] pt_arr [50];

    scytale_decryption dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .key_N   (key_N),
        .key_M   (key_M),
        .data_o  (data_o),
        .valid_o (valid_o),
        .busy    (busy),
        .error   (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic str2q(input string s, output logic [7:0] q [$]);
        q = {};
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    endtask

    task automatic send_ct();
        foreach (ct_q[i]) begin
            valid_i = 1'b1;
            data_i  = ct_q[i];
            tick();
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    task automatic send_token();
        valid_i = 1'b1;
        data_i  = 8'hFA;
        tick();
        valid_i = 1'b0;
        data_i  = 8'h00;
    endtask

    // Called in T+1; optionally drives junk and key changes while busy.
    task automatic expect_pt(input string tag, input bit noise);
        chk({tag, " setup busy"}, 16'(busy), 16'd1);
        chk({tag, " setup valid"}, 16'(valid_o), 16'd0);
        chk({tag, " setup error"}, 16'(error), 16'd0);
        for (int i = 0; i < pt_q.size(); i++) begin
            if (noise) begin
                valid_i = 1'b1;
                data_i  = (i == 2) ? 8'hFA : 8'h5A;
                key_N   = 8'h01;
                key_M   = 8'h01;
            end
            tick();
            chk($sformatf("%s out%0d valid", tag, i), 16'(valid_o), 16'd1);
            chk($sformatf("%s out%0d data", tag, i), 16'(data_o), 16'(pt_q[i]));
            chk($sformatf("%s out%0d busy", tag, i), 16'(busy), 16'd1);
        end
        valid_i = 1'b0;
        data_i  = 8'h00;
        tick();
        chk({tag, " done busy"}, 16'(busy), 16'd0);
        chk({tag, " done valid"}, 16'(valid_o), 16'd0);
        chk({tag, " done data"}, 16'(data_o), 16'd0);
    endtask

    task automatic expect_err(input string tag);
        chk({tag, " err pulse"}, 16'(error), 16'd1);
        chk({tag, " err busy"}, 16'(busy), 16'd0);
        chk({tag, " err valid"}, 16'(valid_o), 16'd0);
        tick();
        chk({tag, " err clear"}, 16'(error), 16'd0);
        chk({tag, " err busy2"}, 16'(busy), 16'd0);
        chk({tag, " err valid2"}, 16'(valid_o), 16'd0);
    endtask

    initial begin
        rst_n   = 1'b1;
        valid_i = 1'b0;
        data_i  = 8'h00;
        key_N   = 8'hFF;
        key_M   = 8'hFF;
        tick();
        tick();
        chk("rst data_o", 16'(data_o), 16'd0);
        chk("rst valid_o", 16'(valid_o), 16'd0);
        chk("rst busy", 16'(busy), 16'd0);
        chk("rst error", 16'(error), 16'd0);
        rst_n = 1'b0;
        tick();

        // Token with empty buffer: nothing happens.
        send_token();
        chk("empty tok error", 16'(error), 16'd0);
        chk("empty tok busy", 16'(busy), 16'd0);
        tick();
        chk("empty tok error2", 16'(error), 16'd0);
        chk("empty tok valid", 16'(valid_o), 16'd0);

        // Basic 3x2 decrypt.
        key_N = 8'h03; key_M = 8'h02;
        str2q("ADBECF", ct_q);
        str2q("ABCDEF", pt_q);
        send_ct();
        send_token();
        expect_pt("basic", 1'b0);

        // Wrap-around 4x3.
        key_N = 8'h04; key_M = 8'h03;
        str2q("HOLEWDLO!LR!", ct_q);
        str2q("HELLOWORLD!!", pt_q);
        send_ct();
        send_token();
        expect_pt("wrap", 1'b0);

        // Register-file default key: length mismatch.
        key_N = 8'hFF; key_M = 8'hFF;
        str2q("ABCDE", ct_q);
        send_ct();
        send_token();
        expect_err("mismatch");
        key_N = 8'h03; key_M = 8'h02;
        str2q("ADBECF", ct_q);
        str2q("ABCDEF", pt_q);
        send_ct();
        send_token();
        expect_pt("after mismatch", 1'b0);

        // Zero key rejected even when other field matches nothing.
        key_N = 8'h00; key_M = 8'h02;
        str2q("ADBECF", ct_q);
        send_ct();
        send_token();
        expect_err("zero key");

        // Overflow: 51 characters with a 5x10 key.
        key_N = 8'h05; key_M = 8'h0A;
        for (int i = 0; i < 50; i++) pt_arr[i] = 8'h30 + 8'(i);
        ct_q = {};
        pt_q = {};
        for (int i = 0; i < 50; i++) pt_q.push_back(pt_arr[i]);
        // Ciphertext reads the 10x5 grid column by column.
        for (int c = 0; c < 5; c++)
            for (int r = 0; r < 10; r++)
                ct_q.push_back(pt_arr[r * 5 + c]);
        ct_q.push_back(8'h7E);
        send_ct();
        send_token();
        expect_err("overflow");
        void'(ct_q.pop_back());
        send_ct();
        send_token();
        expect_pt("full50", 1'b0);

        // Inputs and key changes while busy are ignored.
        key_N = 8'h03; key_M = 8'h02;
        str2q("ADBECF", ct_q);
        str2q("ABCDEF", pt_q);
        send_ct();
        send_token();
        expect_pt("busy noise", 1'b1);
        key_N = 8'h03; key_M = 8'h02;
        send_ct();
        send_token();
        expect_pt("after noise", 1'b0);

        // Reset in the middle of output.
        send_ct();
        send_token();
        chk("midrst setup busy", 16'(busy), 16'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("midrst out%0d", i), 16'(data_o), 16'(pt_q[i]));
        end
        rst_n = 1'b1;
        #1;
        chk("midrst valid drop", 16'(valid_o), 16'd0);
        chk("midrst busy drop", 16'(busy), 16'd0);
        chk("midrst data drop", 16'(data_o), 16'd0);
        #1;
        rst_n = 1'b0;
        tick();
        chk("midrst post busy", 16'(busy), 16'd0);
        send_ct();
        send_token();
        expect_pt("after midrst", 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
